instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_pc_next.sv | 19 +
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states and halt causes.
package instr_fetch_pkg;

    // Fetch FSM states; the encodings are fixed so other blocks may decode them.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    // Reason fetch stopped; reported on halt_cause until reset.
    typedef enum logic [1:0] {
        HALT_NONE     = 2'b00,
        HALT_ILL      = 2'b01,
        HALT_MISALIGN = 2'b10
    } halt_cause_t;

    // Byte distance between sequential instructions.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-fetch-address selection: sequential pc+4 (wrapping) or a branch target,
// plus a flag for taken branches whose target is not word aligned.
module fetch_pc_next
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // Pure combinational select; the 32-bit add wraps naturally modulo 2^32.
    always_comb begin
        next_pc    = branch_taken ? branch_target : pc + INSTR_BYTES;
        misaligned = branch_taken && (branch_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, issues one outstanding request at a
// time to instruction memory, presents the fetched word to decode with a
// valid/ready handshake, and halts on illegal instructions or misaligned
// branch targets reported by decode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        ill_instr,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    fetch_state_t state_q, state_d;
    halt_cause_t  halt_cause_q, halt_cause_d;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  instruction_q;
    logic [31:0]  pc_q;
    logic         load_word;
    logic         advance;
    logic [31:0]  next_pc;
    logic         misaligned;

    fetch_pc_next u_pc_next (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    // State register; reset returns to REQ so fetch restarts at RESET_PC.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-enable decode; decode's illegal flag outranks a consume.
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        load_word    = 1'b0;
        advance      = 1'b0;
        case (state_q)
            ST_REQ: begin
                // Any rvalid here is a stale response from before a reset and is dropped.
                if (imem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d   = ST_HOLD;
                    load_word = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ill_instr) begin
                    state_d      = ST_HALT;
                    halt_cause_d = HALT_ILL;
                end else if (instr_ready) begin
                    if (misaligned) begin
                        state_d      = ST_HALT;
                        halt_cause_d = HALT_MISALIGN;
                    end else begin
                        state_d = ST_REQ;
                        advance = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Datapath registers: fetched word, its address, the next fetch address, halt reason.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            instruction_q <= 32'h0000_0000;
            pc_q          <= RESET_PC;
            halt_cause_q  <= HALT_NONE;
        end else begin
            if (load_word) begin
                instruction_q <= imem_rdata;
                pc_q          <= fetch_pc_q;
            end
            if (advance) begin
                fetch_pc_q <= next_pc;
            end
            halt_cause_q <= halt_cause_d;
        end
    end

    // Outputs decode directly from state; the request is masked while reset is held.
    always_comb begin
        imem_req    = (state_q == ST_REQ) && !rst;
        imem_addr   = fetch_pc_q;
        instr_valid = (state_q == ST_HOLD);
        halted      = (state_q == ST_HALT);
        instruction = instruction_q;
        pc          = pc_q;
        halt_cause  = halt_cause_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a
// randomized run, compared against a transaction-level model of the fetch
// stream (expected next address, memory contents as a function of address).
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        ill_instr = 1'b0;
    logic        halted;
    logic [1:0]  halt_cause;

    int checks = 0;
    int errors = 0;

    // Model: the address the fetch unit should request next.
    logic [31:0] exp_pc;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc            (pc),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ill_instr     (ill_instr),
        .halted        (halted),
        .halt_cause    (halt_cause)
    );

    always #5 clk = ~clk;

    // Memory image as a function of address; 0x100 holds addi x1,x0,5.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hBEEF};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Assert reset mid-cycle, verify outputs clear asynchronously, release on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", pc, RST_PC);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_cause", {30'h0, halt_cause}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RST_PC;
        #1;
        check("post_rst_req", {31'h0, imem_req}, 32'h1);
    endtask

    // One memory transaction at exp_pc with the given ready/response delays.
    task automatic do_fetch(input int rdy_dly, input int rv_dly);
        check("req_high", {31'h0, imem_req}, 32'h1);
        check("req_addr", imem_addr, exp_pc);
        for (int i = 0; i < rdy_dly; i++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            check("req_stall_req", {31'h0, imem_req}, 32'h1);
            check("req_stall_addr", imem_addr, exp_pc);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("wait_req_low", {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < rv_dly; i++) begin
            @(negedge clk);
            check("wait_no_valid", {31'h0, instr_valid}, 32'h0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(exp_pc);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        check("hold_valid", {31'h0, instr_valid}, 32'h1);
        check("hold_instr", instruction, mem_word(exp_pc));
        check("hold_pc", pc, exp_pc);
    endtask

    // Keep instr_ready low for n cycles while waving branch inputs, which must be ignored.
    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            instr_ready   = 1'b0;
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = $urandom();
            @(negedge clk);
            check("stall_valid", {31'h0, instr_valid}, 32'h1);
            check("stall_instr", instruction, mem_word(exp_pc));
            check("stall_pc", pc, exp_pc);
            check("stall_req", {31'h0, imem_req}, 32'h0);
        end
        branch_taken = 1'b0;
    endtask

    // Consume the held word, optionally with a branch; a misaligned target must halt.
    task automatic consume(input logic br, input logic [31:0] tgt);
        logic [31:0] held_pc;
        held_pc       = exp_pc;
        instr_ready   = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        @(negedge clk);
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        if (br && (tgt % 4 != 0)) begin
            check("mis_halted", {31'h0, halted}, 32'h1);
            check("mis_cause", {30'h0, halt_cause}, 32'h2);
            check("mis_pc", pc, held_pc);
            check("mis_valid", {31'h0, instr_valid}, 32'h0);
        end else begin
            exp_pc = br ? tgt : held_pc + 32'd4;
            check("next_valid", {31'h0, instr_valid}, 32'h0);
            check("next_req", {31'h0, imem_req}, 32'h1);
            check("next_addr", imem_addr, exp_pc);
        end
    endtask

    // Stay halted for n cycles: no requests, no valid word, cause and pc frozen.
    task automatic check_halted(input int n, input logic [1:0] cause, input logic [31:0] hpc);
        for (int i = 0; i < n; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_req", {31'h0, imem_req}, 32'h0);
            check("halt_valid", {31'h0, instr_valid}, 32'h0);
            check("halt_flag", {31'h0, halted}, 32'h1);
            check("halt_cause", {30'h0, halt_cause}, {30'h0, cause});
            check("halt_pc", pc, hpc);
        end
        imem_ready = 1'b0;
    endtask

    initial begin
        exp_pc = RST_PC;
        @(negedge clk);

        // Reset values and first fetch at RESET_PC with back-to-back handshakes.
        do_reset();
        do_fetch(0, 0);
        consume(1'b0, 32'h0);

        // Stalled handshakes, then decode back-pressure for five cycles.
        do_fetch(2, 1);
        stall(5);
        consume(1'b0, 32'h0);

        // Aligned branches, then a misaligned target from pc 0x200.
        do_fetch(0, 0);
        consume(1'b1, 32'h0000_0200);
        do_fetch(1, 0);
        consume(1'b1, 32'h0000_0080);
        do_fetch(0, 2);
        consume(1'b1, 32'h0000_0200);
        do_fetch(0, 0);
        consume(1'b1, 32'h0000_0082);
        check_halted(5, 2'b10, 32'h0000_0200);

        // Illegal instruction without consume at pc 0x10.
        do_reset();
        do_fetch(0, 0);
        consume(1'b1, 32'h0000_0010);
        do_fetch(0, 0);
        ill_instr   = 1'b1;
        instr_ready = 1'b0;
        @(negedge clk);
        ill_instr = 1'b0;
        check("ill_halted", {31'h0, halted}, 32'h1);
        check("ill_cause", {30'h0, halt_cause}, 32'h1);
        check("ill_valid", {31'h0, instr_valid}, 32'h0);
        check("ill_pc", pc, 32'h0000_0010);
        check_halted(20, 2'b01, 32'h0000_0010);

        // Sequential wrap from the top of the address space.
        do_reset();
        do_fetch(0, 0);
        consume(1'b1, 32'hFFFF_FFFC);
        do_fetch(0, 0);
        consume(1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset while a response is outstanding; the late response must be dropped.
        do_fetch(0, 0);
        consume(1'b0, 32'h0);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("midrst_wait", {31'h0, imem_req}, 32'h0);
        do_reset();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("stray_valid", {31'h0, instr_valid}, 32'h0);
        check("stray_addr", imem_addr, RST_PC);
        check("stray_req", {31'h0, imem_req}, 32'h1);
        do_fetch(0, 1);
        consume(1'b0, 32'h0);

        // Randomized fetch stream with random delays, stalls and aligned branches.
        for (int n = 0; n < 40; n++) begin
            do_fetch($urandom_range(0, 2), $urandom_range(0, 2));
            stall($urandom_range(0, 3));
            consume(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC);
        end

        // Illegal flag outranks a consume carrying a misaligned branch.
        do_fetch(0, 0);
        ill_instr     = 1'b1;
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0003;
        @(negedge clk);
        ill_instr    = 1'b0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        check_halted(3, 2'b01, exp_pc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
